d_latch_checker: RTL and testbench
==================================

# d_latch_checker

Synthesizable response checker for the gated D latch (`data_input`, `hold_input`, `Q`, `Q_hat`). It samples the latch's inputs and outputs and keeps a cycle-accurate reference model of the latch. After each input change it waits a settle window, then compares the latch outputs against the model. It sits beside the latch under test on the FPGA and reports mismatches through saturating counters and a sticky flag, replacing waveform inspection.

## Interface
Parameters:
- `SETTLE_CYCLES`, 2: clock cycles to wait after a synchronized input change before comparing (1..15).
- `CNT_W`, 8: width of `err_count` and `check_count`.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of counters and sticky flag.
- `check_en` in 1: enables checking when high.
- `dut_data` in 1: latch `data_input`, asynchronous to `clk`.
- `dut_hold` in 1: latch `hold_input`, asynchronous to `clk`.
- `dut_q` in 1: latch `Q`.
- `dut_q_hat` in 1: latch `Q_hat`.
- `model_q` out 1: reference model output.
- `mismatch` out 1: one-cycle pulse when a check fails.
- `comp_err` out 1: one-cycle pulse when `Q_hat != ~Q` at a check.
- `err_sticky` out 1: set on any failed check, held until `clear` or reset.
- `err_count` out CNT_W: failed checks, saturating.
- `check_count` out CNT_W: completed checks, saturating.
- `busy` out 1: high in SETTLE or CHECK.

## Operation
- **Input synchronization:** all four `dut_*` inputs pass through 2-flop synchronizers (`s_data`, `s_hold`, `s_q`, `s_qh`). Everything downstream uses only the synchronized values.
- **Reference model:**
  - When `s_hold == 0` (transparent), `model_q <= s_data`.
  - When `s_hold == 1` (opaque), `model_q` holds its value.
  - The model updates every cycle regardless of `check_en`.
- **Change detect:** `chg` is high when `s_data` or `s_hold` differs from its value in the previous cycle.
- **FSM states:** IDLE, ARMED, SETTLE, CHECK.
  - IDLE: entered when `check_en == 0`, from any state. Goes to ARMED when `check_en == 1`.
  - ARMED: `chg` → SETTLE, loading the settle counter with `SETTLE_CYCLES-1`.
  - SETTLE: `chg` reloads the counter and stays in SETTLE. Counter at 0 with no `chg` → CHECK. Otherwise the counter decrements.
  - CHECK (one cycle):
    - Without `chg`: evaluate `fail = (s_q != model_q)`, plus the complement term when the macro is enabled (see Configuration). Then go to ARMED.
    - With `chg`: discard the comparison and go to SETTLE with the counter reloaded.
- **Results** are registered on the edge that leaves CHECK:
  - `check_count` increments.
  - On `fail`: `mismatch` pulses, `err_count` increments, `err_sticky` is set.
- **Saturation:** both counters stop at 2^CNT_W-1.
- **`clear`:** zeroes both counters and `err_sticky` and suppresses that cycle's result pulses and increments. `clear` wins over a simultaneous check result. The FSM and the model are not affected.

## Timing
- Reset values: `model_q`=0, `mismatch`=0, `comp_err`=0, `err_sticky`=0, `err_count`=0, `check_count`=0, `busy`=0. FSM=IDLE, synchronizers=0.
- Latency from a `dut_data`/`dut_hold` edge to the result pulse is 2 cycles sync + 1 cycle change detect + `SETTLE_CYCLES` + 1 cycle CHECK.
- With the default `SETTLE_CYCLES`=2, the pulse arrives 6 cycles after the input edge.
- `mismatch` and `comp_err` are high for exactly one cycle per failed check.
- Asserting `rst_n` low mid-SETTLE or mid-CHECK aborts the check immediately. No result is recorded.
- Dropping `check_en` during CHECK discards the result. The FSM is in IDLE on the next cycle.

## Configuration
- `D_LATCH_CHECKER_COMP_EN` defined:
  - `fail` also includes `s_qh != ~s_q`.
  - `comp_err` pulses alongside `mismatch` when the complement term fails.
- Not defined:
  - The `s_qh` synchronizer and the complement logic are removed.
  - `comp_err` is tied to 0.
  - `dut_q_hat` is ignored.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0 and FSM IDLE. Release with `check_en`=1 → FSM ARMED, `busy`=0.
- **Transparent pass:** `hold`=0, `data` 0→1, correct latch (`Q`=1, `Q_hat`=0) → `model_q`=1. `check_count`=1 on cycle 6, `mismatch` never asserts.
- **Opaque hold:** `hold`=1, then `data` 1→0 while `Q` stays 1 → `model_q` stays 1. `check_count` +1, `err_count`=0.
- **Fault injection:** force `Q`=0 while the model is 1 → `mismatch` one-cycle pulse, `err_count`=1, `err_sticky`=1. With the macro defined and `Q_hat`=0, `comp_err` also pulses.
- **Retrigger:** toggle `data` every cycle for 5 cycles, then hold stable → exactly one check occurs, after the final change.
- **Saturation and clear:** with `CNT_W`=2, inject 5 faults → `err_count`=3. Assert `clear` in the same cycle as a 6th fault → `err_count`=0 and `err_sticky`=0 with no pulse.

Source files
------------

// File: rtl/d_latch_checker.sv
// Response checker for a gated D latch: synchronizes the latch pins, runs a reference model, compares after a settle window.
// Latency: result pulse 2 (sync) + 1 (change detect) + SETTLE_CYCLES + 1 (check) cycles after a data/hold edge.
// No backpressure; D_LATCH_CHECKER_COMP_EN adds the Q_hat == ~Q complement check.
module d_latch_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             check_en,
    input  logic             dut_data,
    input  logic             dut_hold,
    input  logic             dut_q,
    input  logic             dut_q_hat,
    output logic             model_q,
    output logic             mismatch,
    output logic             comp_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ARMED, SETTLE, CHECK} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] data_sync_q, hold_sync_q, q_sync_q;
    logic       data_prev_q, hold_prev_q;
    logic       s_data, s_hold, s_q;
    logic       chg, q_fail, comp_fail, fail;
    logic [CNT_W-1:0] err_count_d, check_count_d;

    assign s_data = data_sync_q[1];
    assign s_hold = hold_sync_q[1];
    assign s_q    = q_sync_q[1];

`ifdef D_LATCH_CHECKER_COMP_EN
    logic [1:0] qh_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qh_sync_q <= 2'b00;
        end else begin
            qh_sync_q <= {qh_sync_q[0], dut_q_hat};
        end
    end

    assign comp_fail = (qh_sync_q[1] != ~s_q);
`else
    logic unused_q_hat;

    assign unused_q_hat = dut_q_hat;
    assign comp_fail    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_q <= 2'b00;
            hold_sync_q <= 2'b00;
            q_sync_q    <= 2'b00;
            data_prev_q <= 1'b0;
            hold_prev_q <= 1'b0;
            model_q     <= 1'b0;
        end else begin
            data_sync_q <= {data_sync_q[0], dut_data};
            hold_sync_q <= {hold_sync_q[0], dut_hold};
            q_sync_q    <= {q_sync_q[0], dut_q};
            data_prev_q <= s_data;
            hold_prev_q <= s_hold;
            // Transparent while hold is low, opaque otherwise; independent of check_en.
            if (!s_hold) begin
                model_q <= s_data;
            end
        end
    end

    assign chg    = (s_data != data_prev_q) || (s_hold != hold_prev_q);
    assign q_fail = (s_q != model_q);
    assign fail   = q_fail || comp_fail;

    assign err_count_d   = (err_count == '1)   ? err_count   : err_count + 1'b1;
    assign check_count_d = (check_count == '1) ? check_count : check_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            busy        <= 1'b0;
            mismatch    <= 1'b0;
            comp_err    <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
            check_count <= '0;
        end else begin
            mismatch <= 1'b0;
            comp_err <= 1'b0;
            if (!check_en) begin
                state_q <= IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARMED;
                        busy    <= 1'b0;
                    end
                    ARMED: begin
                        if (chg) begin
                            state_q <= SETTLE;
                            cnt_q   <= RELOAD;
                            busy    <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (chg) begin
                            cnt_q <= RELOAD;
                        end else if (cnt_q == 4'd0) begin
                            state_q <= CHECK;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    CHECK: begin
                        if (chg) begin
                            state_q <= SETTLE;
                            cnt_q   <= RELOAD;
                        end else begin
                            state_q <= ARMED;
                            busy    <= 1'b0;
                            if (!clear) begin
                                check_count <= check_count_d;
                                if (fail) begin
                                    mismatch   <= 1'b1;
                                    comp_err   <= comp_fail;
                                    err_count  <= err_count_d;
                                    err_sticky <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any result landing on the same edge.
            if (clear) begin
                err_count   <= '0;
                check_count <= '0;
                err_sticky  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_d_latch_checker.sv
// Bench for d_latch_checker: vector table plus hand-written retrigger, abort, saturation and clear sequences.
module tb_d_latch_checker;

`ifdef D_LATCH_CHECKER_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic clk, rst_n, clear, check_en;
    logic dut_data, dut_hold, dut_q, dut_q_hat;

    logic       model_q, mismatch, comp_err, err_sticky, busy;
    logic [7:0] err_count, check_count;

    logic       s_model_q, s_mismatch, s_comp_err, s_err_sticky, s_busy;
    logic [1:0] s_err_count, s_check_count;

    d_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .check_en(check_en),
        .dut_data(dut_data), .dut_hold(dut_hold), .dut_q(dut_q), .dut_q_hat(dut_q_hat),
        .model_q(model_q), .mismatch(mismatch), .comp_err(comp_err), .err_sticky(err_sticky),
        .err_count(err_count), .check_count(check_count), .busy(busy)
    );

    d_latch_checker #(.SETTLE_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .check_en(check_en),
        .dut_data(dut_data), .dut_hold(dut_hold), .dut_q(dut_q), .dut_q_hat(dut_q_hat),
        .model_q(s_model_q), .mismatch(s_mismatch), .comp_err(s_comp_err), .err_sticky(s_err_sticky),
        .err_count(s_err_count), .check_count(s_check_count), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic d, h, q, qh;
        logic exp_model, exp_qfail, exp_cfail;
    } vec_t;

    typedef struct {
        logic model, mism, cerr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    int tests = 0;
    int fails = 0;
    int exp_checks = 0;
    int exp_errs = 0;
    logic exp_sticky = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic h, input logic q, input logic qh);
        dut_data  = d;
        dut_hold  = h;
        dut_q     = q;
        dut_q_hat = qh;
    endtask

    task automatic push_exp(input logic m, input logic qf, input logic cf);
        exp_t e;
        e.model = m;
        e.mism  = qf | (COMP & cf);
        e.cerr  = COMP & cf;
        sb.push_back(e);
    endtask

    // Waits (bounded) for the main checker to finish a check, then scores it.
    task automatic await_result(input string name);
        int n;
        bit got;
        logic [7:0] prev;
        exp_t e;
        prev = check_count;
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (check_count != prev) got = 1'b1;
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk({name, "_unexpected_check"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        exp_checks++;
        if (e.mism) begin
            exp_errs++;
            exp_sticky = 1'b1;
        end
        chk({name, "_latency"}, n, 6);
        chk({name, "_model_q"}, model_q, e.model);
        chk({name, "_mismatch"}, mismatch, e.mism);
        chk({name, "_comp_err"}, comp_err, e.cerr);
        chk({name, "_check_count"}, check_count, exp_checks);
        chk({name, "_err_count"}, err_count, exp_errs);
        chk({name, "_err_sticky"}, err_sticky, exp_sticky);
        @(negedge clk);
        chk({name, "_pulse_width"}, {mismatch, comp_err}, 2'b00);
    endtask

    initial begin
        //          d     h     q     qh    model qfail cfail
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        clear = 1'b0;
        check_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", {model_q, mismatch, comp_err, err_sticky, busy}, 5'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_check_count", check_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("armed_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("idle_no_check", check_count, 0);

        // Table-driven transparent / opaque / fault vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].d, vecs[i].h, vecs[i].q, vecs[i].qh);
            push_exp(vecs[i].exp_model, vecs[i].exp_qfail, vecs[i].exp_cfail);
            await_result($sformatf("vec%0d", i));
        end

        // Retrigger: five back-to-back data toggles in opaque mode give one check
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            dut_data = ~dut_data;
        end
        push_exp(1'b1, 1'b0, 1'b0);
        await_result("retrigger");
        repeat (10) @(negedge clk);
        chk("retrigger_single", check_count, exp_checks);

        // Dropping check_en during CHECK discards the result
        dut_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("settle_busy", busy, 1);
        @(negedge clk);
        check_en = 1'b0;
        @(negedge clk);
        chk("en_drop_busy", busy, 0);
        chk("en_drop_no_pulse", mismatch, 0);
        repeat (8) @(negedge clk);
        chk("en_drop_discard", check_count, exp_checks);
        check_en = 1'b1;
        @(negedge clk);

        // Reset mid-SETTLE aborts the check
        dut_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_check_count", check_count, 0);
        chk("abort_sticky", err_sticky, 0);
        chk("abort_model_q", model_q, 0);
        exp_checks = 0;
        exp_errs = 0;
        exp_sticky = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_result", check_count, 0);

        // Five faults: main counts 5, the 2-bit instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            logic d;
            d = (i % 2 == 0) ? 1'b1 : 1'b0;
            drive(d, 1'b0, ~d, d);
            push_exp(d, 1'b1, 1'b0);
            await_result($sformatf("fault%0d", i));
        end
        chk("sat_err_count", s_err_count, 3);
        chk("sat_check_count", s_check_count, 3);
        chk("sat_sticky", s_err_sticky, 1);

        // Clear on the same edge as a sixth fault result
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_sat_err_count", s_err_count, 0);
        chk("clear_sat_sticky", s_err_sticky, 0);
        chk("clear_sat_check_count", s_check_count, 0);
        chk("clear_no_pulse", {mismatch, s_mismatch, comp_err, s_comp_err}, 4'b0);
        chk("clear_err_count", err_count, 0);
        chk("clear_check_count", check_count, 0);
        @(negedge clk);
        chk("clear_after_pulse", {mismatch, s_mismatch}, 2'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
